// File: rtl/ifid_pkg.sv
// ifid_pkg: shared state encoding and default bubble for the IF/ID skid stage
package ifid_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: instruction+pc register with load enable and synchronous clear-to-NOP
module pipe_slot #(
   parameter int DATA_W = 32,
   parameter int PC_W = 32,
   parameter logic [DATA_W-1:0] NOP = '0
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_instr,
   input  logic [PC_W-1:0]   i_pc,
   output logic [DATA_W-1:0] o_instr,
   output logic [PC_W-1:0]   o_pc
);
   always_ff @(posedge clk or posedge i_reset)
      if (i_reset) begin
         o_instr <= NOP;
         o_pc <= '0;
      end else if (i_clear) begin
         o_instr <= NOP;
         o_pc <= '0;
      end else if (i_load) begin
         o_instr <= i_instr;
         o_pc <= i_pc;
      end
endmodule

// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: IF/ID register with valid/ready handshake, 2-entry skid buffer,
// flush, halt and a saturating stall-cycle counter.
module ifid_skid_stage import ifid_pkg::*; #(
   parameter int DATA_W = 32,
   parameter int PC_W = 32,
   parameter logic [DATA_W-1:0] NOP = DATA_W'(NOP_DEFAULT),
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_instruction,
   input  logic [PC_W-1:0]   i_pc,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_instruction,
   output logic [PC_W-1:0]   o_pc,
   input  logic              i_flush,
   input  logic              i_halt,
   output logic [CNT_W-1:0]  o_stall_cnt
);
   state_t state, state_nxt;
   logic in_fire, out_fire;
   logic main_ld, main_clr, skid_ld, skid_clr;
   logic [DATA_W-1:0] skid_instr, main_d_instr;
   logic [PC_W-1:0] skid_pc, main_d_pc;

   // o_ready is gated by reset so IF cannot push while reset is held
   assign o_ready = !i_reset && !i_halt && state != FULL;
   assign o_valid = !i_halt && state != EMPTY;
   assign in_fire = i_valid && o_ready;
   assign out_fire = o_valid && i_ready;

   always_comb begin
      main_ld = (state == EMPTY && in_fire) || (state == ONE && in_fire && out_fire) ||
                (state == FULL && out_fire);
      main_clr = i_flush || (state == ONE && out_fire && !in_fire);
      skid_ld = state == ONE && in_fire && !out_fire;
      skid_clr = i_flush || (state == FULL && out_fire);
      main_d_instr = state == FULL ? skid_instr : i_instruction;
      main_d_pc = state == FULL ? skid_pc : i_pc;
      state_nxt = i_flush ? EMPTY :
                  state == EMPTY ? (in_fire ? ONE : EMPTY) :
                  state == ONE ? (in_fire && !out_fire ? FULL : out_fire && !in_fire ? EMPTY : ONE) :
                  (out_fire ? ONE : FULL);
   end

   always_ff @(posedge clk or posedge i_reset)
      if (i_reset) begin
         state <= EMPTY;
         o_stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (o_valid && !i_ready && !i_flush && o_stall_cnt != '1)
            o_stall_cnt <= o_stall_cnt + 1'b1;
      end

   pipe_slot #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP(NOP)) u_main (
      .clk(clk), .i_reset(i_reset), .i_load(main_ld), .i_clear(main_clr),
      .i_instr(main_d_instr), .i_pc(main_d_pc), .o_instr(o_instruction), .o_pc(o_pc)
   );

   pipe_slot #(.DATA_W(DATA_W), .PC_W(PC_W), .NOP(NOP)) u_skid (
      .clk(clk), .i_reset(i_reset), .i_load(skid_ld), .i_clear(skid_clr),
      .i_instr(i_instruction), .i_pc(i_pc), .o_instr(skid_instr), .o_pc(skid_pc)
   );
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: directed checks of streaming, skid, flush, halt, reset and counter saturation
module tb_ifid_skid_stage;
   logic clk = 1'b0;
   logic i_reset = 1'b1;
   logic i_valid = 1'b0, i_ready = 1'b0, i_flush = 1'b0, i_halt = 1'b0;
   logic [31:0] i_instruction = '0, i_pc = '0;
   logic o_ready, o_valid, o_ready4, o_valid4;
   logic [31:0] o_instruction, o_pc, o_instruction4, o_pc4;
   logic [15:0] o_stall_cnt;
   logic [3:0] o_stall_cnt4;
   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ifid_skid_stage dut (
      .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_instruction(i_instruction), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
      .o_instruction(o_instruction), .o_pc(o_pc), .i_flush(i_flush), .i_halt(i_halt),
      .o_stall_cnt(o_stall_cnt)
   );

   ifid_skid_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready4),
      .i_instruction(i_instruction), .i_pc(i_pc), .o_valid(o_valid4), .i_ready(i_ready),
      .o_instruction(o_instruction4), .o_pc(o_pc4), .i_flush(i_flush), .i_halt(i_halt),
      .o_stall_cnt(o_stall_cnt4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] ins, input logic [31:0] pc);
      i_valid = 1'b1;
      i_instruction = ins;
      i_pc = pc;
   endtask

   initial begin
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 0);
      chk("rst_instr", o_instruction, 0);
      chk("rst_cnt", o_stall_cnt, 0);
      tick();
      i_reset = 1'b0;
      #1;
      chk("rel_ready", o_ready, 1);
      chk("rel_valid", o_valid, 0);
      // back-to-back streaming
      i_ready = 1'b1;
      push(32'h0043_0820, 32'h0);
      tick();
      chk("s0_valid", o_valid, 1);
      chk("s0_instr", o_instruction, 32'h0043_0820);
      chk("s0_pc", o_pc, 32'h0);
      push(32'h8C22_0004, 32'h4);
      tick();
      chk("s1_instr", o_instruction, 32'h8C22_0004);
      chk("s1_pc", o_pc, 32'h4);
      chk("s1_ready", o_ready, 1);
      push(32'hAC22_0008, 32'h8);
      tick();
      chk("s2_instr", o_instruction, 32'hAC22_0008);
      chk("s2_pc", o_pc, 32'h8);
      i_valid = 1'b0;
      tick();
      chk("s3_valid", o_valid, 0);
      chk("s3_instr", o_instruction, 0);
      chk("s3_cnt", o_stall_cnt, 0);
      // skid fill and drain
      i_ready = 1'b0;
      push(32'h11, 32'h20);
      tick();
      chk("k0_instr", o_instruction, 32'h11);
      chk("k0_cnt", o_stall_cnt, 0);
      push(32'h22, 32'h24);
      tick();
      chk("k1_ready", o_ready, 0);
      chk("k1_valid", o_valid, 1);
      chk("k1_instr", o_instruction, 32'h11);
      chk("k1_cnt", o_stall_cnt, 1);
      i_valid = 1'b0;
      tick();
      chk("k2_cnt", o_stall_cnt, 2);
      chk("k2_pc", o_pc, 32'h20);
      i_ready = 1'b1;
      tick();
      chk("k3_instr", o_instruction, 32'h22);
      chk("k3_pc", o_pc, 32'h24);
      chk("k3_valid", o_valid, 1);
      tick();
      chk("k4_valid", o_valid, 0);
      chk("k4_cnt", o_stall_cnt, 2);
      // flush while FULL with incoming instruction
      i_ready = 1'b0;
      push(32'h55, 32'h30);
      tick();
      push(32'h66, 32'h34);
      tick();
      chk("f0_cnt", o_stall_cnt, 3);
      push(32'h33, 32'h38);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      i_valid = 1'b0;
      #1;
      chk("f1_valid", o_valid, 0);
      chk("f1_instr", o_instruction, 0);
      chk("f1_pc", o_pc, 0);
      chk("f1_ready", o_ready, 1);
      chk("f1_cnt", o_stall_cnt, 3);
      tick();
      chk("f2_valid", o_valid, 0);
      // flush in ONE while in_fire would be true
      push(32'h77, 32'h40);
      tick();
      push(32'h33, 32'h44);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      i_valid = 1'b0;
      #1;
      chk("f3_valid", o_valid, 0);
      chk("f3_cnt", o_stall_cnt, 3);
      tick();
      chk("f4_instr", o_instruction, 0);
      // halt for 5 cycles in ONE
      push(32'h44, 32'h10);
      tick();
      i_valid = 1'b0;
      i_halt = 1'b1;
      #1;
      chk("h0_valid", o_valid, 0);
      chk("h0_ready", o_ready, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("h1_cnt", o_stall_cnt, 3);
      chk("h1_valid", o_valid, 0);
      i_halt = 1'b0;
      #1;
      chk("h2_valid", o_valid, 1);
      chk("h2_instr", o_instruction, 32'h44);
      chk("h2_pc", o_pc, 32'h10);
      i_ready = 1'b1;
      tick();
      chk("h3_valid", o_valid, 0);
      chk("h3_cnt", o_stall_cnt, 3);
      // asynchronous reset while FULL
      i_ready = 1'b0;
      push(32'h88, 32'h50);
      tick();
      push(32'h99, 32'h54);
      tick();
      i_valid = 1'b0;
      chk("r0_ready", o_ready, 0);
      chk("r0_cnt", o_stall_cnt, 4);
      i_reset = 1'b1;
      #1;
      chk("r1_valid", o_valid, 0);
      chk("r1_ready", o_ready, 0);
      chk("r1_instr", o_instruction, 0);
      chk("r1_cnt", o_stall_cnt, 0);
      tick();
      i_reset = 1'b0;
      #1;
      chk("r2_ready", o_ready, 1);
      chk("r2_valid", o_valid, 0);
      tick();
      chk("r3_valid", o_valid, 0);
      // saturation of the 4-bit counter
      push(32'hAA, 32'h60);
      tick();
      i_valid = 1'b0;
      chk("c0_cnt4", o_stall_cnt4, 0);
      for (int i = 0; i < 14; i++) tick();
      chk("c1_cnt4", o_stall_cnt4, 14);
      for (int i = 0; i < 6; i++) tick();
      chk("c2_cnt4", o_stall_cnt4, 15);
      chk("c2_cnt16", o_stall_cnt, 20);
      chk("c2_instr4", o_instruction4, 32'hAA);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
